// File: rtl/avalon_cmpt_cpu_jtag_scan_master.sv
// avalon_cmpt_cpu_jtag_scan_master
//
// Purpose: drives one IR+DR scan into a virtual JTAG TAP from the system clock.
// TCK is a free-running divide of clk. tms/tdi change on TCK falling edges, and
// tdo is sampled on TCK rising edges. After reset the block walks the TAP
// through Test-Logic-Reset into Run-Test/Idle. It then waits in RTI for a start
// request.
//
// Optional feature: define AVALON_CMPT_CPU_JTAG_SCAN_MASTER_IR_SKIP_EN to remember
// the last IR loaded since reset. A scan whose ir_val matches that IR then goes
// straight to the DR path and skips the IR segment.
//
// Parameters:
//   TCK_DIV  clk cycles per TCK half-period (1..255)
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   start    one-clk scan request, honoured only while idle in RTI
//   ir_val   2-bit IR value, LSB first
//   dr_val   38-bit DR value, LSB first
//   dr_len   DR bit count (0 rejected, >38 clamped to 38)
//   busy     scan (or post-reset TLR walk) in progress
//   done     one-clk pulse at scan completion
//   err      one-clk pulse when a start is rejected
//   dr_out   captured TDO bits, bit i from shift i
//   tck, tms, tdi  JTAG drive; tdo  JTAG return
module avalon_cmpt_cpu_jtag_scan_master #(
  parameter int TCK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  ir_val,
  input  logic [37:0] dr_val,
  input  logic [5:0]  dr_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [37:0] dr_out,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam logic [5:0] DR_MAX   = 6'd38;
  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  // state_q is the TAP state during the current TCK period; tms_q is the value
  // presented to the TAP during that period.
  typedef enum logic [3:0] {
    TLR_WAIT = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    SEL_IR   = 4'd3,
    CAP_IR   = 4'd4,
    SH_IR    = 4'd5,
    EX1_IR   = 4'd6,
    UPD_IR   = 4'd7,
    SEL_DR2  = 4'd8,
    CAP_DR   = 4'd9,
    SH_DR    = 4'd10,
    EX1_DR   = 4'd11,
    UPD_DR   = 4'd12
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [37:0] dr_out_q, dr_out_d;
  logic [1:0]  ir_q, ir_d;
  logic [37:0] dr_q, dr_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  tlr_q, tlr_d;
  logic [37:0] cap_q, cap_d;
  logic        skip_q, skip_d;

  logic        tick_s;
  logic        rise_s;
  logic        fall_s;
  logic        idle_s;
  logic        accept_s;
  logic        reject_s;
  logic [5:0]  eff_len_s;
  logic [5:0]  nxt_cnt_s;
  logic        last_bit_s;
  logic        nxt_last_s;
  logic        ir_match_s;

  assign tick_s     = (div_q == DIV_LAST);
  assign rise_s     = tick_s & ~tck_q;
  assign fall_s     = tick_s & tck_q;
  assign idle_s     = (state_q == RTI) & ~busy_q;
  assign accept_s   = start & idle_s & (dr_len != 6'd0);
  assign reject_s   = start & idle_s & (dr_len == 6'd0);
  assign eff_len_s  = (dr_len > DR_MAX) ? DR_MAX : dr_len;
  assign nxt_cnt_s  = cnt_q + 6'd1;
  assign last_bit_s = (cnt_q == (len_q - 6'd1));
  assign nxt_last_s = (nxt_cnt_s == (len_q - 6'd1));

`ifdef AVALON_CMPT_CPU_JTAG_SCAN_MASTER_IR_SKIP_EN
  logic [1:0] last_ir_q, last_ir_d;
  logic       ir_vld_q, ir_vld_d;

  assign ir_match_s = ir_vld_q & (ir_val == last_ir_q);

  // Remember the IR once the TAP has passed Update-IR.
  always_comb begin
    last_ir_d = last_ir_q;
    ir_vld_d  = ir_vld_q;
    if (fall_s && (state_q == UPD_IR)) begin
      last_ir_d = ir_q;
      ir_vld_d  = 1'b1;
    end else begin
      last_ir_d = last_ir_q;
      ir_vld_d  = ir_vld_q;
    end
  end

  // Last-IR registers; reset forgets the IR so the next scan reloads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ir_q <= 2'b00;
      ir_vld_q  <= 1'b0;
    end else begin
      last_ir_q <= last_ir_d;
      ir_vld_q  <= ir_vld_d;
    end
  end
`else
  assign ir_match_s = 1'b0;
`endif

  // TCK divider, request handling and TAP sequencing (all changes on TCK fall).
  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 8'd1;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dr_out_d = dr_out_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tlr_d    = tlr_q;
    cap_d    = cap_q;
    skip_d   = skip_q;

    if (tick_s) begin
      div_d = 8'd0;
      tck_d = ~tck_q;
    end else begin
      div_d = div_q + 8'd1;
    end

    // busy covers the post-reset TLR walk as well as scans
    if (state_q == TLR_WAIT) begin
      busy_d = 1'b1;
    end else begin
      busy_d = busy_q;
    end

    if (reject_s) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end

    if (accept_s) begin
      busy_d   = 1'b1;
      ir_d     = ir_val;
      dr_d     = dr_val;
      len_d    = eff_len_s;
      skip_d   = ir_match_s;
      cap_d    = 38'd0;
      dr_out_d = 38'd0;
    end else begin
      skip_d   = skip_q;
    end

    if (rise_s && (state_q == SH_DR)) begin
      cap_d[cnt_q] = tdo;
    end else begin
      cnt_d = cnt_q;
    end

    if (fall_s) begin
      case (state_q)
        TLR_WAIT: begin
          if (tlr_q == 3'd5) begin
            state_d = RTI;
            busy_d  = 1'b0;
            tms_d   = 1'b0;
            tlr_d   = 3'd0;
          end else begin
            tlr_d = tlr_q + 3'd1;
            tms_d = (tlr_q != 3'd4);
          end
        end
        RTI: begin
          // The first period of a scan is spent in RTI with tms=1
          if (busy_q && tms_q) begin
            state_d = SEL_DR;
            tms_d   = ~skip_q;
          end else if (busy_q) begin
            tms_d = 1'b1;
          end else begin
            tms_d = 1'b0;
          end
        end
        SEL_DR: begin
          state_d = skip_q ? CAP_DR : SEL_IR;
          tms_d   = 1'b0;
        end
        SEL_IR: begin
          state_d = CAP_IR;
          tms_d   = 1'b0;
        end
        CAP_IR: begin
          state_d = SH_IR;
          cnt_d   = 6'd0;
          tdi_d   = ir_q[0];
          tms_d   = 1'b0;
        end
        SH_IR: begin
          if (cnt_q[0]) begin
            state_d = EX1_IR;
            cnt_d   = 6'd0;
            tdi_d   = 1'b0;
            tms_d   = 1'b1;
          end else begin
            cnt_d = nxt_cnt_s;
            tdi_d = ir_q[1];
            tms_d = 1'b1;
          end
        end
        EX1_IR: begin
          state_d = UPD_IR;
          tms_d   = 1'b1;
        end
        UPD_IR: begin
          state_d = SEL_DR2;
          tms_d   = 1'b0;
        end
        SEL_DR2: begin
          state_d = CAP_DR;
          tms_d   = 1'b0;
        end
        CAP_DR: begin
          state_d = SH_DR;
          cnt_d   = 6'd0;
          tdi_d   = dr_q[0];
          tms_d   = (len_q == 6'd1);
        end
        SH_DR: begin
          if (last_bit_s) begin
            state_d = EX1_DR;
            cnt_d   = 6'd0;
            tdi_d   = 1'b0;
            tms_d   = 1'b1;
          end else begin
            cnt_d = nxt_cnt_s;
            tdi_d = dr_q[nxt_cnt_s];
            tms_d = nxt_last_s;
          end
        end
        EX1_DR: begin
          state_d = UPD_DR;
          tms_d   = 1'b0;
        end
        UPD_DR: begin
          state_d  = RTI;
          tms_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          dr_out_d = cap_q;
        end
        default: begin
          state_d = TLR_WAIT;
          tms_d   = 1'b1;
          tlr_d   = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TLR_WAIT;
      div_q    <= 8'd0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dr_out_q <= 38'd0;
      ir_q     <= 2'b00;
      dr_q     <= 38'd0;
      len_q    <= 6'd0;
      cnt_q    <= 6'd0;
      tlr_q    <= 3'd0;
      cap_q    <= 38'd0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dr_out_q <= dr_out_d;
      ir_q     <= ir_d;
      dr_q     <= dr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tlr_q    <= tlr_d;
      cap_q    <= cap_d;
      skip_q   <= skip_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign dr_out = dr_out_q;
  assign tck    = tck_q;
  assign tms    = tms_q;
  assign tdi    = tdi_q;

endmodule

// File: tb/tb_avalon_cmpt_cpu_jtag_scan_master.sv
// Self-checking bench for avalon_cmpt_cpu_jtag_scan_master (TCK_DIV=2).
// The TAP side is observed at every TCK rising edge. Expected tms sequences,
// period counts and captured data are built from the JTAG scan rules.
module tb_avalon_cmpt_cpu_jtag_scan_master;

  localparam int TCK_DIV = 2;
`ifdef AVALON_CMPT_CPU_JTAG_SCAN_MASTER_IR_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [1:0]  ir_val  = 2'b00;
  logic [37:0] dr_val  = 38'd0;
  logic [5:0]  dr_len  = 6'd0;
  logic        busy, done, err, tck, tms, tdi, tdo;
  logic [37:0] dr_out;

  // tdo source: 0 loopback of tdi, 1 tied high, 2 tied low, 3 random per TCK
  int   tdo_mode = 2;
  logic tdo_r    = 1'b0;
  assign tdo = (tdo_mode == 0) ? tdi : tdo_r;

  int errors = 0;
  int checks = 0;
  int done_total = 0;
  int err_total  = 0;
  bit tms_seen[$];
  bit tdi_seen[$];
  bit tdo_seen[$];

  // reference model: IR held by the TAP since the last reset
  bit         m_ir_vld  = 1'b0;
  logic [1:0] m_last_ir = 2'b00;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    logic [5:0]  len;
    int          mode;
    bit          disturb;
    bit          is_err;
    logic [37:0] exp_dr;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  avalon_cmpt_cpu_jtag_scan_master #(.TCK_DIV(TCK_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .ir_val  (ir_val),
    .dr_val  (dr_val),
    .dr_len  (dr_len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .dr_out  (dr_out),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .tdo     (tdo)
  );

  // What the TAP sees on each TCK rising edge
  always @(posedge tck) begin
    tms_seen.push_back(tms);
    tdi_seen.push_back(tdi);
    tdo_seen.push_back(tdo);
    if (tdo_mode == 3) tdo_r <= 1'($urandom);
  end

  // Count done/err pulse cycles
  always @(negedge clk) begin
    if (done) done_total <= done_total + 1;
    if (err)  err_total  <= err_total + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tck"},    64'(tck),    64'(0));
    chk({tag, "_tms"},    64'(tms),    64'(1));
    chk({tag, "_tdi"},    64'(tdi),    64'(0));
    chk({tag, "_busy"},   64'(busy),   64'(0));
    chk({tag, "_done"},   64'(done),   64'(0));
    chk({tag, "_err"},    64'(err),    64'(0));
    chk({tag, "_dr_out"}, 64'(dr_out), 64'(0));
  endtask

  // Release reset and check the 5x tms=1, 1x tms=0 walk into RTI
  task automatic check_tlr(input string tag);
    int base;
    int d0;
    bit ok;
    logic [5:0] pat;
    base = tms_seen.size();
    d0   = done_total;
    @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    chk({tag, "_busy_high"}, 64'(ok), 64'(1));
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({tag, "_busy_fall"}, 64'(ok), 64'(1));
    chk({tag, "_periods"}, 64'(tms_seen.size() - base), 64'(6));
    pat = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (base + i < tms_seen.size()) pat[5 - i] = tms_seen[base + i];
    end
    chk({tag, "_tms_seq"}, 64'(pat), 64'(6'b111110));
    repeat (4) @(negedge clk);
    chk({tag, "_no_done"}, 64'(done_total - d0), 64'(0));
    m_ir_vld = 1'b0;
  endtask

  // Rejected start: err pulse, no busy, TAP left in RTI
  task automatic do_err(input logic [1:0] ir, input logic [37:0] dr);
    int e0;
    int bad;
    e0 = err_total;
    @(negedge clk);
    ir_val = ir; dr_val = dr; dr_len = 6'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'(1));
    chk("err_busy", 64'(busy), 64'(0));
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (busy || tms || err) bad++;
    end
    chk("err_idle", 64'(bad), 64'(0));
    chk("err_once", 64'(err_total - e0), 64'(1));
  endtask

  // One scan checked against the model
  task automatic run_scan(input logic [1:0] ir, input logic [37:0] dr, input logic [5:0] len,
                          input int mode, input bit disturb, input bit use_exp,
                          input logic [37:0] exp_dr);
    int n, base, d0, e0, ds, per, bad_tms, bad_tdi;
    bit skip, ok;
    logic [37:0] want;
    bit etms[$];
    n    = (len > 6'd38) ? 38 : int'(len);
    skip = SKIP_EN && m_ir_vld && (m_last_ir == ir);
    per  = skip ? (5 + n) : (12 + n);
    ds   = skip ? 3 : 10;
    d0   = done_total;
    e0   = err_total;
    tdo_mode = mode;
    tdo_r    = (mode == 1);
    @(negedge clk);
    ir_val = ir; dr_val = dr; dr_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 64'(busy), 64'(1));
    chk("accept_dr_out_clear", 64'(dr_out), 64'(0));
    @(negedge tck);
    base = tms_seen.size();
    if (disturb) begin
      repeat (10) @(negedge clk);
      start = 1'b1; dr_len = 6'd0; ir_val = ~ir; dr_val = ~dr;
      @(negedge clk);
      start = 1'b0;
    end
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_seen", 64'(ok), 64'(1));
    chk("done_busy_low", 64'(busy), 64'(0));
    chk("tck_periods", 64'(tms_seen.size() - base), 64'(per));
    // expected tms per TCK period
    etms.push_back(1'b1);
    if (!skip) begin
      etms.push_back(1'b1); etms.push_back(1'b0); etms.push_back(1'b0);
      etms.push_back(1'b0); etms.push_back(1'b1);
      etms.push_back(1'b1); etms.push_back(1'b1); etms.push_back(1'b0); etms.push_back(1'b0);
    end else begin
      etms.push_back(1'b0); etms.push_back(1'b0);
    end
    for (int k = 0; k < n; k++) etms.push_back(k == n - 1);
    etms.push_back(1'b1); etms.push_back(1'b0);
    bad_tms = 0;
    for (int i = 0; i < etms.size(); i++) begin
      if (base + i >= tms_seen.size()) bad_tms++;
      else if (tms_seen[base + i] != etms[i]) bad_tms++;
    end
    chk("tms_seq", 64'(bad_tms), 64'(0));
    bad_tdi = 0;
    if (!skip) begin
      if (base + 5 >= tdi_seen.size()) bad_tdi++;
      else if (tdi_seen[base + 4] != ir[0] || tdi_seen[base + 5] != ir[1]) bad_tdi++;
    end
    want = 38'd0;
    for (int k = 0; k < n; k++) begin
      if (base + ds + k >= tdi_seen.size()) bad_tdi++;
      else begin
        if (tdi_seen[base + ds + k] != dr[k]) bad_tdi++;
        want[k] = tdo_seen[base + ds + k];
      end
    end
    chk("tdi_bits", 64'(bad_tdi), 64'(0));
    if (use_exp) want = exp_dr;
    chk("dr_out", 64'(dr_out), 64'(want));
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_total - d0), 64'(1));
    chk("no_err", 64'(err_total - e0), 64'(0));
    if (!skip) begin
      m_last_ir = ir;
      m_ir_vld  = 1'b1;
    end
  endtask

  initial begin
    int base, d0;
    bit ok;
    tbl[0] = '{2'b01, 38'h2A_AAAA_AAAA, 6'd38, 0, 1'b0, 1'b0, 38'h2A_AAAA_AAAA};
    tbl[1] = '{2'b10, 38'h00_0000_0000, 6'd0,  0, 1'b0, 1'b1, 38'h00_0000_0000};
    tbl[2] = '{2'b11, 38'h15_5555_5555, 6'd50, 1, 1'b1, 1'b0, 38'h3F_FFFF_FFFF};
    tbl[3] = '{2'b00, 38'h3F_FFFF_FFFF, 6'd1,  0, 1'b0, 1'b0, 38'h00_0000_0001};
    tbl[4] = '{2'b01, 38'h00_0000_00F0, 6'd8,  0, 1'b0, 1'b0, 38'h00_0000_00F0};
    tbl[5] = '{2'b10, 38'h12_3456_789A, 6'd12, 2, 1'b0, 1'b0, 38'h00_0000_0000};
    tbl[6] = '{2'b10, 38'h00_0000_0003, 6'd39, 0, 1'b0, 1'b0, 38'h00_0000_0003};

    // reset values and post-reset TLR walk
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    check_tlr("tlr");

    // table-driven scans
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_err) do_err(tbl[i].ir, tbl[i].dr);
      else run_scan(tbl[i].ir, tbl[i].dr, tbl[i].len, tbl[i].mode, tbl[i].disturb,
                    1'b1, tbl[i].exp_dr);
    end

    // back-to-back scans with the same IR
    run_scan(2'b01, 38'h01_2345_6789, 6'd38, 0, 1'b0, 1'b1, 38'h01_2345_6789);
    run_scan(2'b10, 38'h3C_3C3C_3C3C, 6'd38, 0, 1'b0, 1'b1, 38'h3C_3C3C_3C3C);
    run_scan(2'b10, 38'h03_C3C3_C3C3, 6'd38, 0, 1'b0, 1'b1, 38'h03_C3C3_C3C3);

    // randomized scans with random tdo
    for (int r = 0; r < 6; r++) begin
      run_scan(2'($urandom), {6'($urandom), 32'($urandom)}, 6'($urandom_range(1, 63)),
               3, 1'b0, 1'b0, 38'd0);
    end

    // reset in the middle of a scan
    d0 = done_total;
    tdo_mode = 0;
    @(negedge clk);
    ir_val = 2'b01; dr_val = 38'h2A_AAAA_AAAA; dr_len = 6'd38; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge tck);
    base = tms_seen.size();
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (tms_seen.size() - base >= 20) begin ok = 1'b1; break; end
    end
    chk("mid_reach_tck20", 64'(ok), 64'(1));
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (3) @(negedge clk);
    chk("mid_no_done", 64'(done_total - d0), 64'(0));
    check_tlr("mid_tlr");

    // scan after the mid-scan reset reloads the IR
    run_scan(2'b01, 38'h00_DEAD_BEEF, 6'd38, 0, 1'b0, 1'b1, 38'h00_DEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
